// File: rtl/traffic_log_arbiter_if.sv
`default_nettype none
// ============================================================================
// traffic_log_if : record-strobe inputs and log-sink handshake
// Rev 1.0
// ============================================================================
interface traffic_log_if #(
   parameter int N_PORTS  = 5,
   parameter int RECORD_W = 256
);
   localparam int c_PORT_W = $clog2(N_PORTS);

   logic [N_PORTS-1:0]          rec_vld;
   logic [N_PORTS*RECORD_W-1:0] rec_data;
   logic                        out_valid;
   logic                        out_ready;
   logic [RECORD_W-1:0]         out_data;
   logic [c_PORT_W-1:0]         out_port;

   modport master (
      output rec_vld, rec_data, out_ready,
      input  out_valid, out_data, out_port
   );

   modport slave (
      input  rec_vld, rec_data, out_ready,
      output out_valid, out_data, out_port
   );
endinterface
`default_nettype wire

// File: rtl/traffic_log_arbiter.sv
`default_nettype none
// ============================================================================
// traffic_log_arbiter : per-port record holds, round-robin grant, show-ahead
// output FIFO. Optional drop counter: define TRAFFIC_LOG_DROP_CNT_EN.
// Rev 1.0
// ============================================================================
module traffic_log_arbiter #(
   parameter int N_PORTS    = 5,
   parameter int RECORD_W   = 256,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   traffic_log_if.slave        log_if,
   output logic [N_PORTS-1:0]  hold_full_o,
   output logic [31:0]         drop_cnt_o
);
   localparam int c_PORT_W  = $clog2(N_PORTS);
   localparam int c_ADDR_W  = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W   = c_ADDR_W + 1;
   localparam int c_ENTRY_W = c_PORT_W + RECORD_W;

   logic [N_PORTS-1:0]  r_hold_vld;
   logic [RECORD_W-1:0] r_hold_data [N_PORTS];
   logic [c_PORT_W-1:0] r_rr_ptr;
   logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
   logic [c_ADDR_W-1:0] r_wr_ptr;
   logic [c_ADDR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0]  r_count;

   logic                w_pop;
   logic                w_push_ok;
   logic                w_gnt_vld;
   logic [c_PORT_W-1:0] w_gnt_idx;
   logic [c_PORT_W:0]   w_sum;
   logic [c_PORT_W-1:0] w_idx;
   logic [N_PORTS-1:0]  w_gnt_oh;
   logic [c_ENTRY_W-1:0] w_head;

   assign w_pop     = (r_count != '0) && log_if.out_ready;
   // A full FIFO still accepts a grant when the head leaves in the same cycle
   assign w_push_ok = (r_count < c_CNT_W'(FIFO_DEPTH)) || w_pop;

   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      w_sum     = '0;
      w_idx     = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         w_sum = {1'b0, r_rr_ptr} + (c_PORT_W+1)'(i);
         if (w_sum >= (c_PORT_W+1)'(N_PORTS))
            w_sum = w_sum - (c_PORT_W+1)'(N_PORTS);
         w_idx = w_sum[c_PORT_W-1:0];
         if (!w_gnt_vld && r_hold_vld[w_idx] && w_push_ok) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_idx;
         end
      end
   end

   for (genvar p = 0; p < N_PORTS; p++) begin : g_gnt_oh
      assign w_gnt_oh[p] = w_gnt_vld && (w_gnt_idx == c_PORT_W'(p));
   end

   // A hold being granted this cycle is free to take a new strobe
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_hold_vld <= '0;
      end else begin
         for (int p = 0; p < N_PORTS; p++) begin
            if (log_if.rec_vld[p] && (!r_hold_vld[p] || w_gnt_oh[p]))
               r_hold_vld[p] <= 1'b1;
            else if (w_gnt_oh[p])
               r_hold_vld[p] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int p = 0; p < N_PORTS; p++) begin
         if (!rst_i && log_if.rec_vld[p] && (!r_hold_vld[p] || w_gnt_oh[p]))
            r_hold_data[p] <= log_if.rec_data[p*RECORD_W +: RECORD_W];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_rr_ptr <= '0;
      else if (w_gnt_vld)
         r_rr_ptr <= (w_gnt_idx == c_PORT_W'(N_PORTS-1)) ? '0 : w_gnt_idx + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && w_gnt_vld)
         r_mem[r_wr_ptr] <= {w_gnt_idx, r_hold_data[w_gnt_idx]};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_gnt_vld)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_gnt_vld, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Outputs are forced to zero while empty so stale entries never show
   assign w_head           = r_mem[r_rd_ptr];
   assign log_if.out_valid = (r_count != '0);
   assign log_if.out_data  = log_if.out_valid ? w_head[RECORD_W-1:0] : '0;
   assign log_if.out_port  = log_if.out_valid ? w_head[c_ENTRY_W-1 -: c_PORT_W] : '0;
   assign hold_full_o      = r_hold_vld;

`ifdef TRAFFIC_LOG_DROP_CNT_EN
   logic [N_PORTS-1:0] w_drop;
   logic [31:0]        w_drop_num;
   logic [32:0]        w_drop_sum;
   logic [31:0]        r_drop_cnt;

   always_comb begin
      w_drop_num = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         w_drop[p]  = log_if.rec_vld[p] && r_hold_vld[p] && !w_gnt_oh[p];
         w_drop_num = w_drop_num + 32'(w_drop[p]);
      end
   end

   assign w_drop_sum = {1'b0, r_drop_cnt} + {1'b0, w_drop_num};

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_drop_cnt <= '0;
      else
         r_drop_cnt <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
   end

   assign drop_cnt_o = r_drop_cnt;
`else
   assign drop_cnt_o = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_traffic_log_arbiter.sv
`default_nettype none
// ============================================================================
// tb_traffic_log_arbiter : directed stimulus with queue scoreboard and monitor
// Rev 1.0
// ============================================================================
module tb_traffic_log_arbiter;
   localparam int c_N = 5;
   localparam int c_W = 256;

   typedef struct packed {
      logic [2:0]     port;
      logic [c_W-1:0] data;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [c_N-1:0] hold_full;
   logic [31:0] drop_cnt;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];
   logic [31:0] exp_drop;

   traffic_log_if #(.N_PORTS(c_N), .RECORD_W(c_W)) log_if ();

   traffic_log_arbiter #(.N_PORTS(c_N), .RECORD_W(c_W), .FIFO_DEPTH(8)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .log_if     (log_if),
      .hold_full_o(hold_full),
      .drop_cnt_o (drop_cnt)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [c_W-1:0] mk(input logic [31:0] s);
      return {8{s}};
   endfunction

   task automatic chk(input string name, input logic [c_W-1:0] act, input logic [c_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulse(input logic [c_N-1:0] mask, input logic [31:0] base);
      for (int p = 0; p < c_N; p++)
         if (mask[p]) log_if.rec_data[p*c_W +: c_W] = mk(base + 32'(p));
      log_if.rec_vld = mask;
      tick();
      log_if.rec_vld = '0;
   endtask

   task automatic push_exp(input int port, input logic [c_W-1:0] d);
      exp_t e;
      e.port = 3'(port);
      e.data = d;
      sb_q.push_back(e);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      log_if.out_ready = 1'b1;
      while ((log_if.out_valid || hold_full != '0) && n < 40) begin
         tick();
         n++;
      end
      chk(name, {255'd0, log_if.out_valid}, '0);
   endtask

   // Scoreboard monitor: every accepted head must match the oldest expectation
   always @(negedge clk_i) begin
      if (!rst_i && log_if.out_valid && log_if.out_ready) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: got port %0d data %h, expected nothing",
                     log_if.out_port, log_if.out_data);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_port", c_W'(log_if.out_port), c_W'(e.port));
            chk("sb_data", log_if.out_data, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef TRAFFIC_LOG_DROP_CNT_EN
      exp_drop = 32'd1;
`else
      exp_drop = 32'd0;
`endif
      rst_i            = 1'b1;
      log_if.rec_vld   = '0;
      log_if.rec_data  = '0;
      log_if.out_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", c_W'(log_if.out_valid), '0);
      chk("rst_data",  log_if.out_data, '0);
      chk("rst_port",  c_W'(log_if.out_port), '0);
      chk("rst_hold",  c_W'(hold_full), '0);
      chk("rst_drop",  c_W'(drop_cnt), '0);
      rst_i = 1'b0;
      tick();

      // Single record on port 2
      log_if.rec_data[2*c_W +: c_W] = {32{8'hA5}};
      log_if.rec_vld = 5'b00100;
      push_exp(2, {32{8'hA5}});
      tick();
      log_if.rec_vld = '0;
      chk("single_hold",   c_W'(hold_full), c_W'(5'b00100));
      chk("single_valid0", c_W'(log_if.out_valid), '0);
      tick();
      chk("single_valid1", c_W'(log_if.out_valid), c_W'(1'b1));
      chk("single_port",   c_W'(log_if.out_port), c_W'(2));
      chk("single_data",   log_if.out_data, {32{8'hA5}});
      tick();
      chk("single_valid2", c_W'(log_if.out_valid), '0);

      // Port 0 alone moves the pointer to 1
      push_exp(0, mk(32'h10));
      pulse(5'b00001, 32'h10);
      tick();
      tick();
      tick();
      chk("rr_ptr_1", c_W'(dut.r_rr_ptr), c_W'(1));

      // Ports 0,1,4 together from rr_ptr=1 drain as 1,4,0
      push_exp(1, mk(32'h21));
      push_exp(4, mk(32'h24));
      push_exp(0, mk(32'h20));
      pulse(5'b10011, 32'h20);
      tick();
      chk("rr_first",  c_W'(log_if.out_port), c_W'(1));
      tick();
      chk("rr_second", c_W'(log_if.out_port), c_W'(4));
      tick();
      chk("rr_third",  c_W'(log_if.out_port), c_W'(0));
      tick();
      chk("rr_done",   c_W'(log_if.out_valid), '0);
      chk("rr_ptr_end", c_W'(dut.r_rr_ptr), c_W'(1));

      // Fill the FIFO with the sink stalled
      log_if.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push_exp(0, mk(32'h100 + 32'(i)));
         pulse(5'b00001, 32'h100 + 32'(i));
         tick();
      end
      chk("full_count", c_W'(dut.r_count), c_W'(8));
      chk("full_hold0", c_W'(hold_full), '0);
      push_exp(0, mk(32'h108));
      pulse(5'b00001, 32'h108);
      tick();
      chk("ninth_held", c_W'(hold_full), c_W'(5'b00001));
      chk("ninth_count", c_W'(dut.r_count), c_W'(8));
      pulse(5'b00001, 32'h1FF);
      chk("tenth_drop", c_W'(drop_cnt), c_W'(exp_drop));
      chk("tenth_hold", c_W'(hold_full), c_W'(5'b00001));
      chk("full_head",  log_if.out_data, mk(32'h100));

      // One pop with a grant in the same cycle
      log_if.out_ready = 1'b1;
      tick();
      log_if.out_ready = 1'b0;
      chk("popgnt_count", c_W'(dut.r_count), c_W'(8));
      chk("popgnt_hold",  c_W'(hold_full), '0);
      chk("popgnt_head",  log_if.out_data, mk(32'h101));
      drain("drain_full");

      // Port 3 refilled in the cycle it is granted
      log_if.rec_data[3*c_W +: c_W] = mk(32'h300);
      log_if.rec_vld = 5'b01000;
      push_exp(3, mk(32'h300));
      push_exp(3, mk(32'h301));
      tick();
      log_if.rec_data[3*c_W +: c_W] = mk(32'h301);
      tick();
      log_if.rec_vld = '0;
      chk("refill_hold", c_W'(hold_full), c_W'(5'b01000));
      chk("refill_drop", c_W'(drop_cnt), c_W'(exp_drop));
      drain("drain_refill");
      chk("refill_drop_end", c_W'(drop_cnt), c_W'(exp_drop));

      // Reset with 5 queued and 2 held; these records must never appear
      log_if.out_ready = 1'b0;
      pulse(5'b11111, 32'h400);
      for (int i = 0; i < 5; i++) tick();
      chk("prerst_count", c_W'(dut.r_count), c_W'(5));
      pulse(5'b00110, 32'h500);
      chk("prerst_hold", c_W'(hold_full), c_W'(5'b00110));
      rst_i = 1'b1;
      log_if.rec_data[4*c_W +: c_W] = mk(32'h777);
      log_if.rec_vld = 5'b10000;
      tick();
      log_if.rec_vld = '0;
      chk("midrst_valid", c_W'(log_if.out_valid), '0);
      chk("midrst_data",  log_if.out_data, '0);
      chk("midrst_port",  c_W'(log_if.out_port), '0);
      chk("midrst_hold",  c_W'(hold_full), '0);
      chk("midrst_drop",  c_W'(drop_cnt), '0);
      rst_i = 1'b0;
      log_if.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("postrst_valid", c_W'(log_if.out_valid), '0);
      chk("postrst_hold",  c_W'(hold_full), '0);
      chk("sb_empty",      c_W'(sb_q.size()), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
